z8420_port_ctrl: RTL and testbench

// - One Z8420 PIO port channel (A or B): decodes the CPU control-word stream and holds mode, I/O-select, mask and vector.
// - Evaluates the interrupt condition and drives INTI/INTEN into the downstream daisy-chain interrupt stage.
// - Places the stored vector on DO when that stage asserts VECTEN during interrupt acknowledge.

---
 rtl/z8420_pkg.sv | 15 +
 rtl/z8420_port_match.sv | 79 +++++++
 rtl/z8420_port_ctrl.sv | 117 +++++++++++
 tb/tb_z8420_port_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/z8420_pkg.sv
// z8420_pkg: shared mode codes, control-word FSM states and control-word patterns for the Z8420 PIO port channel
package z8420_pkg;

    localparam logic [1:0] MODE_OUT   = 2'd0;
    localparam logic [1:0] MODE_IN    = 2'd1;
    localparam logic [1:0] MODE_BIDIR = 2'd2;
    localparam logic [1:0] MODE_BIT   = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_IOSEL, ST_MASK} state_e;

    localparam logic [3:0] CW_MODE = 4'hF;
    localparam logic [3:0] CW_ICW  = 4'h7;
    localparam logic [3:0] CW_IEN  = 4'h3;

endpackage

// File: rtl/z8420_port_match.sv
// z8420_port_match: mode-3 bit-match condition and STB_n rising-edge detect, producing the one-cycle INTI pulse
// Ports: clk_i, reset_n_i (sync, active low), mode_i, iosel_i, mask_i, high_i, and_or_i, pi_i, stb_n_i,
//        hist_clr_i (restart match history), mode_wr_i (mode word written this cycle), inti_o.
// Option: Z8420_PORT_SYNC_EN adds a 2-flop synchronizer on pi_i/stb_n_i (INTI latency 3 CLK instead of 1).
module z8420_port_match
    import z8420_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [1:0] mode_i,
    input  logic [7:0] iosel_i,
    input  logic [7:0] mask_i,
    input  logic       high_i,
    input  logic       and_or_i,
    input  logic [7:0] pi_i,
    input  logic       stb_n_i,
    input  logic       hist_clr_i,
    input  logic       mode_wr_i,
    output logic       inti_o
);

    logic [7:0] pi_s;
    logic       stb_s;

`ifdef Z8420_PORT_SYNC_EN
    logic [7:0] pi_m_q, pi_s_q;
    logic       stb_m_q, stb_s_q;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pi_m_q  <= '0;
            pi_s_q  <= '0;
            stb_m_q <= 1'b1;
            stb_s_q <= 1'b1;
        end else begin
            pi_m_q  <= pi_i;
            pi_s_q  <= pi_m_q;
            stb_m_q <= stb_n_i;
            stb_s_q <= stb_m_q;
        end
    end

    assign pi_s  = pi_s_q;
    assign stb_s = stb_s_q;
`else
    assign pi_s  = pi_i;
    assign stb_s = stb_n_i;
`endif

    logic [7:0] mon, act;
    logic       match, match_q, stb_q, inti_q;
    logic       match_d, inti_d;

    assign mon   = iosel_i & ~mask_i;
    assign act   = ~(pi_s ^ {8{high_i}}) & mon;
    assign match = and_or_i ? (act == mon) && (mon != 8'h00) : |act;

    // History is tracked in every mode so a later mode switch starts from true pin state;
    // the write cycle of a mode word itself never fires.
    always_comb begin
        match_d = hist_clr_i ? 1'b0 : match;
        inti_d  = !mode_wr_i && ((mode_i == MODE_BIT) ? (match && !match_q) : (stb_s && !stb_q));
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            match_q <= 1'b0;
            stb_q   <= 1'b1;
            inti_q  <= 1'b0;
        end else begin
            match_q <= match_d;
            stb_q   <= stb_s;
            inti_q  <= inti_d;
        end
    end

    assign inti_o = inti_q;

endmodule

// File: rtl/z8420_port_ctrl.sv
// z8420_port_ctrl: Z8420 PIO port channel - control-word decode FSM, register file, interrupt request and vector drive
// Ports: clk_i, reset_n_i (sync, active low), cwr_i, di_i[7:0], pi_i[7:0], stb_n_i, vecten_i,
//        inti_o, inten_o, do_o[7:0], doe_o, mode_o[1:0], iosel_o[7:0].
// Option: Z8420_PORT_SYNC_EN synchronizes pi_i/stb_n_i inside z8420_port_match.
module z8420_port_ctrl
    import z8420_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       cwr_i,
    input  logic [7:0] di_i,
    input  logic [7:0] pi_i,
    input  logic       stb_n_i,
    input  logic       vecten_i,
    output logic       inti_o,
    output logic       inten_o,
    output logic [7:0] do_o,
    output logic       doe_o,
    output logic [1:0] mode_o,
    output logic [7:0] iosel_o
);

    state_e     st_q, st_d;
    logic [1:0] mode_q, mode_d;
    logic [7:0] iosel_q, iosel_d, mask_q, mask_d, vect_q, vect_d;
    logic       ie_q, ie_d, and_or_q, and_or_d, high_q, high_d;
    logic       mode_wr, hist_clr;

    always_comb begin
        st_d     = st_q;
        mode_d   = mode_q;
        iosel_d  = iosel_q;
        mask_d   = mask_q;
        vect_d   = vect_q;
        ie_d     = ie_q;
        and_or_d = and_or_q;
        high_d   = high_q;
        mode_wr  = 1'b0;
        hist_clr = 1'b0;
        if (cwr_i) begin
            case (st_q)
                // Follow-on bytes are raw data, never decoded as control words.
                ST_IOSEL: begin
                    iosel_d  = di_i;
                    st_d     = ST_IDLE;
                    hist_clr = 1'b1;
                end
                ST_MASK: begin
                    mask_d   = di_i;
                    st_d     = ST_IDLE;
                    hist_clr = 1'b1;
                end
                default: begin
                    if (!di_i[0]) begin
                        vect_d = di_i;
                    end else if (di_i[3:0] == CW_MODE) begin
                        mode_d  = di_i[7:6];
                        mode_wr = 1'b1;
                        if (di_i[7:6] == MODE_BIT) st_d = ST_IOSEL;
                    end else if (di_i[3:0] == CW_ICW) begin
                        ie_d     = di_i[7];
                        and_or_d = di_i[6];
                        high_d   = di_i[5];
                        if (di_i[4]) st_d = ST_MASK;
                    end else if (di_i[3:0] == CW_IEN) begin
                        ie_d = di_i[7];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            st_q     <= ST_IDLE;
            mode_q   <= MODE_IN;
            iosel_q  <= 8'hFF;
            mask_q   <= 8'hFF;
            vect_q   <= 8'h00;
            ie_q     <= 1'b0;
            and_or_q <= 1'b0;
            high_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            mode_q   <= mode_d;
            iosel_q  <= iosel_d;
            mask_q   <= mask_d;
            vect_q   <= vect_d;
            ie_q     <= ie_d;
            and_or_q <= and_or_d;
            high_q   <= high_d;
        end
    end

    z8420_port_match u_match (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .mode_i     (mode_q),
        .iosel_i    (iosel_q),
        .mask_i     (mask_q),
        .high_i     (high_q),
        .and_or_i   (and_or_q),
        .pi_i       (pi_i),
        .stb_n_i    (stb_n_i),
        .hist_clr_i (hist_clr),
        .mode_wr_i  (mode_wr),
        .inti_o     (inti_o)
    );

    // Interrupts stay off while a mask byte is outstanding.
    assign inten_o = ie_q && (st_q != ST_MASK);
    assign do_o    = vecten_i ? vect_q : 8'h00;
    assign doe_o   = vecten_i;
    assign mode_o  = mode_q;
    assign iosel_o = iosel_q;

endmodule

// File: tb/tb_z8420_port_ctrl.sv
// tb_z8420_port_ctrl: directed and randomized checks of z8420_port_ctrl against a behavioural channel model
module tb_z8420_port_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cwr = 1'b0;
    logic [7:0] di = 8'h00;
    logic [7:0] pi = 8'h00;
    logic       stb_n = 1'b1;
    logic       vecten = 1'b0;
    logic       inti, inten, doe;
    logic [7:0] dout, iosel;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

`ifdef Z8420_PORT_SYNC_EN
    localparam bit SYNC = 1'b1;
    localparam int LAT  = 2;
`else
    localparam bit SYNC = 1'b0;
    localparam int LAT  = 0;
`endif

    z8420_port_ctrl dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .cwr_i     (cwr),
        .di_i      (di),
        .pi_i      (pi),
        .stb_n_i   (stb_n),
        .vecten_i  (vecten),
        .inti_o    (inti),
        .inten_o   (inten),
        .do_o      (dout),
        .doe_o     (doe),
        .mode_o    (mode),
        .iosel_o   (iosel)
    );

    always #5 clk = ~clk;

    // Behavioural model: registers as named by the channel, pending follow-on byte as a small integer
    logic [1:0] m_mode;
    logic [7:0] m_iosel, m_mask, m_vect, m_p1, m_p2;
    bit         m_ie, m_and, m_high, m_inti, m_prev_match, m_prev_stb, m_s1, m_s2;
    int         m_pend;

    function automatic bit cond(input logic [7:0] p);
        int mon, act;
        mon = 0;
        act = 0;
        for (int i = 0; i < 8; i++)
            if (m_iosel[i] && !m_mask[i]) begin
                mon++;
                if (p[i] == m_high) act++;
            end
        return m_and ? (mon > 0 && act == mon) : (act > 0);
    endfunction

    task automatic model_edge();
        bit c, se, mw;
        logic [7:0] pe;
        if (!reset_n) begin
            m_mode = 2'd1; m_iosel = 8'hFF; m_mask = 8'hFF; m_vect = 8'h00;
            m_ie = 0; m_and = 0; m_high = 0; m_pend = 0; m_inti = 0;
            m_prev_match = 0; m_prev_stb = 1;
            m_p1 = 8'h00; m_p2 = 8'h00; m_s1 = 1; m_s2 = 1;
        end else begin
            pe = SYNC ? m_p2 : pi;
            se = SYNC ? m_s2 : stb_n;
            c  = cond(pe);
            mw = cwr && m_pend == 0 && di[3:0] == 4'hF;
            m_inti = mw ? 1'b0 : (m_mode == 2'd3 ? (c && !m_prev_match) : (se && !m_prev_stb));
            m_prev_match = (cwr && m_pend != 0) ? 1'b0 : c;
            m_prev_stb = se;
            m_p2 = m_p1; m_p1 = pi; m_s2 = m_s1; m_s1 = stb_n;
            if (cwr) begin
                if (m_pend == 1) begin
                    m_iosel = di; m_pend = 0;
                end else if (m_pend == 2) begin
                    m_mask = di; m_pend = 0;
                end else if (!di[0]) m_vect = di;
                else if (di[3:0] == 4'hF) begin
                    m_mode = di[7:6];
                    if (di[7:6] == 2'd3) m_pend = 1;
                end else if (di[3:0] == 4'h7) begin
                    m_ie = di[7]; m_and = di[6]; m_high = di[5];
                    if (di[4]) m_pend = 2;
                end else if (di[3:0] == 4'h3) m_ie = di[7];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("inti",  {7'd0, inti},  {7'd0, m_inti});
        chk("inten", {7'd0, inten}, {7'd0, m_ie && m_pend != 2});
        chk("do",    dout,          vecten ? m_vect : 8'h00);
        chk("doe",   {7'd0, doe},   {7'd0, vecten});
        chk("mode",  {6'd0, mode},  {6'd0, m_mode});
        chk("iosel", iosel,         m_iosel);
    endtask

    task automatic cw(input logic [7:0] d);
        cwr = 1'b1;
        di  = d;
        tick();
        cwr = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_mode", {6'd0, mode}, 8'd1);
        chk("rst_iosel", iosel, 8'hFF);
        chk("rst_inten", {7'd0, inten}, 8'd0);
        chk("rst_do", dout, 8'h00);
        // vector load and drive
        cw(8'h20);
        vecten = 1'b1;
        tick();
        chk("t1_do", dout, 8'h20);
        chk("t1_doe", {7'd0, doe}, 8'd1);
        vecten = 1'b0;
        tick();
        chk("t1_do_off", dout, 8'h00);
        // mode 3 with follow-on IOSEL byte
        cw(8'hCF);
        chk("t2_mode", {6'd0, mode}, 8'd3);
        cw(8'h0F);
        chk("t2_iosel", iosel, 8'h0F);
        chk("t2_mode_kept", {6'd0, mode}, 8'd3);
        // OR / active-high with pending mask
        cw(8'hB7);
        chk("t3_inten_pend", {7'd0, inten}, 8'd0);
        tick();
        cw(8'hFE);
        chk("t3_inten", {7'd0, inten}, 8'd1);
        tick();
        pi = 8'h01;
        repeat (LAT) tick();
        tick();
        chk("t3_inti_on", {7'd0, inti}, 8'd1);
        tick();
        chk("t3_inti_off", {7'd0, inti}, 8'd0);
        // AND mode
        pi = 8'h00;
        repeat (3) tick();
        cw(8'hCF);
        cw(8'hFF);
        cw(8'hF7);
        cw(8'hFC);
        tick();
        pi = 8'h01;
        repeat (LAT + 2) tick();
        chk("t4_partial", {7'd0, inti}, 8'd0);
        pi = 8'h03;
        repeat (LAT) tick();
        tick();
        chk("t4_inti_on", {7'd0, inti}, 8'd1);
        repeat (4) begin
            tick();
            chk("t4_hold", {7'd0, inti}, 8'd0);
        end
        // strobe mode
        cw(8'h4F);
        tick();
        stb_n = 1'b0;
        repeat (LAT + 2) tick();
        stb_n = 1'b1;
        repeat (LAT) tick();
        tick();
        chk("t5_stb_inti", {7'd0, inti}, 8'd1);
        tick();
        cw(8'h03);
        chk("t5_inten_off", {7'd0, inten}, 8'd0);
        stb_n = 1'b0;
        repeat (LAT + 2) tick();
        stb_n = 1'b1;
        repeat (LAT) tick();
        tick();
        chk("t5_inti_no_ie", {7'd0, inti}, 8'd1);
        // reset discards pending IOSEL byte
        cw(8'hCF);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cw(8'h0F);
        chk("t6_mode", {6'd0, mode}, 8'd0);
        chk("t6_iosel", iosel, 8'hFF);
        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset_n = ($urandom % 80) != 0;
            cwr = ($urandom % 4) == 0;
            di = 8'($urandom);
            case ($urandom % 5)
                0: di[3:0] = 4'hF;
                1: di[3:0] = 4'h7;
                2: di[3:0] = 4'h3;
                default: ;
            endcase
            if ($urandom % 3 == 0) pi = 8'($urandom);
            if ($urandom % 3 == 0) stb_n = ~stb_n;
            vecten = ($urandom % 4) == 0;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
